// File: rtl/board_io_panel_if.sv
// Processor-side register port of the front-panel I/O block: single-cycle write,
// one-cycle-latency read with a valid pulse.
interface board_io_panel_if;
  logic        wr_en;
  logic        rd_en;
  logic [2:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rd_valid;

  modport master (output wr_en, rd_en, addr, wr_data, input rd_data, rd_valid);
  modport slave  (input wr_en, rd_en, addr, wr_data, output rd_data, rd_valid);
endinterface

// File: rtl/board_io_panel.sv
// Front-panel I/O: button debounce and press flags, hex digits with blank/blink, LEDs.
// Define BOARD_IO_PANEL_BLINK_EN to build the BLINK register and blink timer.
module board_io_panel #(
  parameter int unsigned NUM_DIGITS      = 8,
  parameter int unsigned NUM_BTN         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned BLINK_CYCLES    = 12500000
) (
  input  logic                    clock,
  input  logic                    reset,
  board_io_panel_if.slave         bus,
  input  logic [NUM_BTN-1:0]      btn_raw,
  output logic [NUM_BTN-1:0]      btn_level,
  output logic [7*NUM_DIGITS-1:0] seg_out,
  output logic [7:0]              leds
);

  localparam int unsigned DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DCW-1:0] DEB_LAST = DCW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTN-1:0]      r_sync1, r_sync2, r_level, r_pressed;
  logic [DCW-1:0]          r_cnt [NUM_BTN];
  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [NUM_DIGITS-1:0]   r_blank;
  logic [7:0]              r_leds;
  logic [31:0]             r_rdData;
  logic                    r_rdValid;
  logic [7*NUM_DIGITS-1:0] r_seg;

  logic [NUM_BTN-1:0]      w_btnSync, w_levelNext, w_rise, w_w1c;
  logic [NUM_DIGITS-1:0]   w_blinkOff, w_blinkReg;
  logic [31:0]             w_rdMux;

  function automatic logic [6:0] hexGlyph(input logic [3:0] v);
    case (v)
      4'h0: hexGlyph = 7'b1000000;
      4'h1: hexGlyph = 7'b1111001;
      4'h2: hexGlyph = 7'b0100100;
      4'h3: hexGlyph = 7'b0110000;
      4'h4: hexGlyph = 7'b0011001;
      4'h5: hexGlyph = 7'b0010010;
      4'h6: hexGlyph = 7'b0000010;
      4'h7: hexGlyph = 7'b1111000;
      4'h8: hexGlyph = 7'b0000000;
      4'h9: hexGlyph = 7'b0010000;
      4'hA: hexGlyph = 7'b0001000;
      4'hB: hexGlyph = 7'b0000011;
      4'hC: hexGlyph = 7'b1000110;
      4'hD: hexGlyph = 7'b0100001;
      4'hE: hexGlyph = 7'b0000110;
      default: hexGlyph = 7'b0001110;
    endcase
  endfunction

  assign w_btnSync = ~r_sync2;

  // A button level is accepted only once the counter has seen it stable long enough
  always_comb begin
    w_levelNext = r_level;
    for (int i = 0; i < int'(NUM_BTN); i++) begin
      if (w_btnSync[i] != r_level[i] && r_cnt[i] == DEB_LAST)
        w_levelNext[i] = w_btnSync[i];
    end
  end

  assign w_rise = w_levelNext & ~r_level;
  assign w_w1c  = (bus.wr_en && bus.addr == 3'd4) ? bus.wr_data[NUM_BTN-1:0] : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_level <= '0;
      for (int i = 0; i < int'(NUM_BTN); i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
      r_level <= w_levelNext;
      for (int i = 0; i < int'(NUM_BTN); i++) begin
        if (w_btnSync[i] == r_level[i] || r_cnt[i] == DEB_LAST) r_cnt[i] <= '0;
        else r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

`ifdef BOARD_IO_PANEL_BLINK_EN
  localparam int unsigned BCW = $clog2(BLINK_CYCLES + 1);
  localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_CYCLES - 1);

  logic [BCW-1:0]        r_blinkCnt;
  logic                  r_phase;
  logic [NUM_DIGITS-1:0] r_blink;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_blinkCnt <= '0;
      r_phase    <= 1'b0;
      r_blink    <= '0;
    end else begin
      if (r_blinkCnt == BLINK_LAST) begin
        r_blinkCnt <= '0;
        r_phase    <= ~r_phase;
      end else begin
        r_blinkCnt <= r_blinkCnt + 1'b1;
      end
      if (bus.wr_en && bus.addr == 3'd2) r_blink <= bus.wr_data[NUM_DIGITS-1:0];
    end
  end

  assign w_blinkReg = r_blink;
  assign w_blinkOff = r_phase ? r_blink : '0;
`else
  assign w_blinkReg = '0;
  assign w_blinkOff = '0;
`endif

  // Reads see the registers as they stood before any write on the same edge
  always_comb begin
    w_rdMux = '0;
    case (bus.addr)
      3'd0: w_rdMux[4*NUM_DIGITS-1:0] = r_digits;
      3'd1: w_rdMux[NUM_DIGITS-1:0]   = r_blank;
      3'd2: w_rdMux[NUM_DIGITS-1:0]   = w_blinkReg;
      3'd3: w_rdMux[NUM_BTN-1:0]      = r_level;
      3'd4: w_rdMux[NUM_BTN-1:0]      = r_pressed;
      3'd5: w_rdMux[7:0]              = r_leds;
      default: w_rdMux = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_digits  <= '0;
      r_blank   <= '0;
      r_leds    <= '0;
      r_pressed <= '0;
      r_rdData  <= '0;
      r_rdValid <= 1'b0;
    end else begin
      if (bus.wr_en && bus.addr == 3'd0) r_digits <= bus.wr_data[4*NUM_DIGITS-1:0];
      if (bus.wr_en && bus.addr == 3'd1) r_blank  <= bus.wr_data[NUM_DIGITS-1:0];
      if (bus.wr_en && bus.addr == 3'd5) r_leds   <= bus.wr_data[7:0];
      r_pressed <= (r_pressed & ~w_w1c) | w_rise;
      if (bus.rd_en) r_rdData <= w_rdMux;
      r_rdValid <= bus.rd_en;
    end
  end

  // Blanking takes priority over the digit value and the blink phase
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) r_seg[7*i +: 7] <= 7'b1000000;
    end else begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        if (r_blank[i] || w_blinkOff[i]) r_seg[7*i +: 7] <= 7'b1111111;
        else r_seg[7*i +: 7] <= hexGlyph(r_digits[4*i +: 4]);
      end
    end
  end

  assign bus.rd_data  = r_rdData;
  assign bus.rd_valid = r_rdValid;
  assign btn_level    = r_level;
  assign seg_out      = r_seg;
  assign leds         = r_leds;

endmodule

// File: doc/board_io_panel.md
# board_io_panel

Parametrised front-panel I/O block for the board top level: debounces NUM_BTN raw push buttons, latches press events, and drives NUM_DIGITS hex seven-segment digits plus 8 LEDs from a small register file. The processor accesses it through a single-cycle memory-mapped read/write port. It replaces the fixed per-digit hex decoders and hard-wired LED constant with software-controlled display, blanking, blinking and button status.

## Interface
- NUM_DIGITS, 8, number of hex digits driven (1..8)
- NUM_BTN, 4, number of push buttons (1..8)
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles before a button level is accepted (10 ms at 50 MHz)
- BLINK_CYCLES, 12500000, cycles per blink half-period
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  register write strobe
- rd_en  in  1  register read strobe
- addr  in  3  register address
- wr_data  in  32  write data
- rd_data  out  32  read data, held until next read
- rd_valid  out  1  one-cycle pulse, cycle after rd_en
- btn_raw  in  NUM_BTN  raw buttons, active-low (0 = pressed), asynchronous
- btn_level  out  NUM_BTN  debounced level, active-high (1 = pressed)
- seg_out  out  7*NUM_DIGITS  digit i on [7i+6:7i]; bit 0 = a … bit 6 = g; active-low
- leds  out  8  LED register

## Operation
- Register map (word addresses; unused bits read 0, writes ignored):
  - 0 DIGITS RW: digit i value in bits [4i+3:4i]
  - 1 BLANK RW: bit i = 1 turns digit i off
  - 2 BLINK RW: bit i = 1 blinks digit i
  - 3 BTN_LEVEL RO: btn_level
  - 4 BTN_PRESSED R/W1C: sticky press flags; write 1 clears bit
  - 5 LEDS RW: bits [7:0] → leds
  - 6, 7: reads return 0, writes ignored
- Buttons: per button a 2-FF synchroniser, inverted to active-high, then a debounce counter. Counter clears whenever the synchronised value equals btn_level; otherwise it increments, and when it reaches DEBOUNCE_CYCLES-1 btn_level takes the new value and the counter clears.
- Press event: btn_level 0→1 sets BTN_PRESSED bit. Release does not set it.
- Display: digit i shows standard active-low hex glyph of its nibble (0 = 7'b1000000, F = 7'b0001110). It shows 7'b1111111 if BLANK[i], or if BLINK[i] and blink phase = 1. BLANK has priority.
- Blink: free-running counter; phase toggles every BLINK_CYCLES cycles; phase 0 after reset.

## Timing
- Reset values: DIGITS 0, BLANK 0, BLINK 0, LEDS 0, BTN_PRESSED 0, btn_level 0, synchroniser stages 1 (released), counters 0, blink phase 0, rd_data 0, rd_valid 0. seg_out shows "0" on every digit and leds = 0 the cycle after reset.
- Write: register updates on the wr_en edge; seg_out and leds reflect it the next cycle. seg_out is registered.
- Read: rd_data and rd_valid register on the rd_en edge, giving 1-cycle latency. rd_valid is high for exactly one cycle per rd_en cycle, so back-to-back reads are allowed.
- Simultaneous wr_en and rd_en to the same address: the read returns the pre-write value.
- Press event and W1C on the same bit in the same cycle: the set wins and the bit stays 1.
- Button latency: btn_level changes 2 + DEBOUNCE_CYCLES cycles after a clean raw edge. Any bounce restarts the count.
- Reset asserted mid-debounce or mid-read: all state returns to reset values on that edge, and no rd_valid follows.

## Configuration
- BOARD_IO_PANEL_BLINK_EN defined: BLINK register, blink counter and phase logic are present as described.
- Undefined: no blink counter is built. BLINK reads 0 and writes are ignored, and digits are never blink-blanked.

## Test plan
- Reset, then read addr 0 → rd_valid one cycle later, rd_data 0; seg_out all digits 7'b1000000, leds 0.
- Write DIGITS = 32'h89ABCDEF → digit 0 = 7'b0001110 (F), digit 7 = 7'b0000000 (8). Write LEDS 8'hA5 → leds 8'hA5.
- DEBOUNCE_CYCLES = 8: hold btn_raw[0] low 5 cycles, high 1, low 20 → btn_level[0] rises once, 10 cycles after the final low edge; BTN_PRESSED reads 1; write 1 → reads 0.
- Press event coincident with W1C to the same bit → BTN_PRESSED bit reads 1.
- BLINK_CYCLES = 4, BLINK = 1, BLANK = 0: digit 0 alternates glyph/off every 4 cycles. Then set BLANK = 1 → digit 0 stays off (7'b1111111).
- Same-cycle write and read of addr 5 (old 8'h00, new 8'h3C) → rd_data 0, next read 8'h3C. Read addr 7 → 0.
